// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle
interface hazard_if #(parameter int CNT_W = 16);
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW;
    logic memtoregE, memtoregM;
    logic branchD, jumpD, pcsrcD, mduseD, mdstartE;
    logic stallF, stallD, flushD, flushE;
    logic forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic md_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, jumpD, pcsrcD, mduseD, mdstartE,
        input  stallF, stallD, flushD, flushE, forwardAD, forwardBD,
        input  forwardAE, forwardBE, md_busy, stall_cnt, flush_cnt
    );
    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, jumpD, pcsrcD, mduseD, mdstartE,
        output stallF, stallD, flushD, flushE, forwardAD, forwardBD,
        output forwardAE, forwardBE, md_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control, mult/div busy sequencing and perf counters
module hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave h
);
    localparam int CW = $clog2(MD_LAT + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic lwstall, brstall, mdstall, busy, stall, redirect;
    function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic [4:0] wm, input logic rwm,
                                         input logic [4:0] ww, input logic rww);
        return (src != 5'd0 && src == wm && rwm) ? 2'b10 :
               (src != 5'd0 && src == ww && rww) ? 2'b01 : 2'b00;
    endfunction
    always_comb begin
        lwstall  = h.memtoregE && h.rtE != 5'd0 && (h.rtE == h.rsD || h.rtE == h.rtD);
        brstall  = h.branchD &&
                   ((h.regwriteE && h.writeregE != 5'd0 && (h.writeregE == h.rsD || h.writeregE == h.rtD)) ||
                    (h.memtoregM && h.writeregM != 5'd0 && (h.writeregM == h.rsD || h.writeregM == h.rtD)));
        busy     = state_q == BUSY || h.mdstartE;
        mdstall  = h.mduseD && busy;
        stall    = lwstall || brstall || mdstall;
        redirect = (h.pcsrcD || h.jumpD) && !stall;
        // Reset forces a bubble: nothing held, both pipeline registers cleared.
        h.stallF    = !rst && stall;
        h.stallD    = !rst && stall;
        h.flushE    = rst || stall;
        h.flushD    = rst || redirect;
        h.md_busy   = !rst && busy;
        h.forwardAD = !rst && h.rsD != 5'd0 && h.rsD == h.writeregM && h.regwriteM;
        h.forwardBD = !rst && h.rtD != 5'd0 && h.rtD == h.writeregM && h.regwriteM;
        h.forwardAE = rst ? 2'b00 : fwd_e(h.rsE, h.writeregM, h.regwriteM, h.writeregW, h.regwriteW);
        h.forwardBE = rst ? 2'b00 : fwd_e(h.rtE, h.writeregM, h.regwriteM, h.writeregW, h.regwriteW);
        h.stall_cnt = stall_cnt_q;
        h.flush_cnt = flush_cnt_q;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (h.mdstartE && MD_LAT > 1) begin
                state_d = BUSY;
                cnt_d   = CW'(MD_LAT - 1);
            end
        end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? IDLE : BUSY;
        end
        stall_cnt_d = (h.stallD && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (h.flushD && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
